// File: rtl/camera_cfg_pkg.sv
// Shared constants and types for the OV5640 register configuration sequencer.
package camera_cfg_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_PWRUP  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd2;
  localparam logic [STATE_W-1:0] ST_XFER   = 3'd3;
  localparam logic [STATE_W-1:0] ST_CHECK  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DELAY  = 3'd5;
  localparam logic [STATE_W-1:0] ST_NEXT   = 3'd6;
  localparam logic [STATE_W-1:0] ST_FINISH = 3'd7;

  // Table entries with this address are waits, not register writes.
  localparam logic [15:0] DELAY_MARKER = 16'hFFFF;
  localparam int unsigned DELAY_UNIT_W = 10;
  localparam int unsigned DELAY_UNIT   = 1 << DELAY_UNIT_W;

  // Idle cycles before each attempt so the bit engine re-arms.
  localparam int unsigned GAP_CYCLES = 3;
  localparam int unsigned GAP_W      = 2;

  localparam int unsigned IDX_W = 9;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  val;
  } reg_entry_t;

  // Counter width able to hold max_count without overflow (never zero).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : int'($clog2(max_count + 1));
  endfunction

endpackage

// File: rtl/camera_reg_lut.sv
// OV5640 init list: index -> {reg_addr, reg_val}; unlisted indices read as a 1-cycle wait.
module camera_reg_lut
  import camera_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output reg_entry_t       entry
);

  logic [23:0] raw;

  // Table lookup; default is a zero-length delay entry so stray indices are harmless.
  always_comb begin
    raw = 24'hFFFF00;
    case (index)
      9'd0:  raw = 24'h3103_11;
      9'd1:  raw = 24'h3008_82;
      9'd2:  raw = 24'h3008_42;
      9'd3:  raw = 24'h3103_03;
      9'd4:  raw = 24'hFFFF_02;
      9'd5:  raw = 24'h3017_FF;
      9'd6:  raw = 24'h3018_FF;
      9'd7:  raw = 24'h3034_1A;
      9'd8:  raw = 24'h3035_11;
      9'd9:  raw = 24'h3036_46;
      9'd10: raw = 24'h3037_13;
      9'd11: raw = 24'h3108_01;
      9'd12: raw = 24'h3630_36;
      9'd13: raw = 24'h3631_0E;
      9'd14: raw = 24'h3632_E2;
      9'd15: raw = 24'h3633_12;
      9'd16: raw = 24'h3621_E0;
      9'd17: raw = 24'h3704_A0;
      9'd18: raw = 24'h3703_5A;
      9'd19: raw = 24'h3715_78;
      9'd20: raw = 24'h3717_01;
      9'd21: raw = 24'h370B_60;
      9'd22: raw = 24'h3705_1A;
      9'd23: raw = 24'h3905_02;
      9'd24: raw = 24'h3906_10;
      9'd25: raw = 24'h3901_0A;
      9'd26: raw = 24'h3731_12;
      9'd27: raw = 24'h3600_08;
      9'd28: raw = 24'h3601_33;
      9'd29: raw = 24'h302D_60;
      9'd30: raw = 24'h3620_52;
      9'd31: raw = 24'h371B_20;
      9'd32: raw = 24'h471C_50;
      9'd33: raw = 24'h3A13_43;
      9'd34: raw = 24'h3A18_00;
      9'd35: raw = 24'h3A19_F8;
      9'd36: raw = 24'h3635_13;
      9'd37: raw = 24'h3636_03;
      9'd38: raw = 24'h3634_40;
      9'd39: raw = 24'h3622_01;
      9'd40: raw = 24'h3C01_34;
      9'd41: raw = 24'h3C04_28;
      9'd42: raw = 24'h3C05_98;
      9'd43: raw = 24'h3C06_00;
      9'd44: raw = 24'h3C07_08;
      9'd45: raw = 24'h3C08_00;
      9'd46: raw = 24'h3C09_1C;
      9'd47: raw = 24'h3C0A_9C;
      9'd48: raw = 24'h3C0B_40;
      9'd49: raw = 24'h4300_61;
      9'd50: raw = 24'h501F_01;
      9'd51: raw = 24'h3008_02;
      default: raw = 24'hFFFF00;
    endcase
  end

  assign entry = raw;

endmodule

// File: rtl/camera_reg_config.sv
// Walks the camera init table, driving the I2C bit engine one entry at a time with retries.
module camera_reg_config
  import camera_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR  = 8'h78,
  parameter int unsigned NUM_REGS  = 252,
  parameter int unsigned PWR_DELAY = 20000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic             clock_i2c,
  input  logic             camera_rst,
  input  logic             tr_end,
  input  logic             ack,
  output logic [31:0]      i2c_data,
  output logic             start,
  output logic [IDX_W-1:0] reg_index,
  output logic             config_done,
  output logic             config_err
);

  localparam int unsigned PWR_W = cnt_width(PWR_DELAY);
  localparam int unsigned TMO_W = cnt_width(TIMEOUT);
  localparam int unsigned RTY_W = cnt_width(MAX_RETRY);
  localparam int unsigned DLY_W = 8 + DELAY_UNIT_W;

  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_DELAY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [PWR_W-1:0]   pwr_cnt, pwr_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
  logic [DLY_W-1:0]   dly_cnt, dly_cnt_nxt;
  logic [RTY_W-1:0]   retry_cnt, retry_cnt_nxt;
  logic               timed_out, timed_out_nxt;
  logic [31:0]        i2c_data_nxt;
  logic               start_nxt;
  logic [IDX_W-1:0]   reg_index_nxt;
  logic               config_done_nxt, config_err_nxt;

  reg_entry_t         entry;
  logic [DLY_W-1:0]   dly_len, dly_last;

  camera_reg_lut u_lut (
    .index (reg_index),
    .entry (entry)
  );

  // Delay entries count in 1024-cycle units; a zero count still costs one cycle.
  assign dly_len  = DLY_W'(i2c_data[7:0]) * DLY_W'(DELAY_UNIT);
  assign dly_last = (dly_len == '0) ? '0 : dly_len - DLY_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    pwr_cnt_nxt     = pwr_cnt;
    gap_cnt_nxt     = gap_cnt;
    tmo_cnt_nxt     = tmo_cnt;
    dly_cnt_nxt     = dly_cnt;
    retry_cnt_nxt   = retry_cnt;
    timed_out_nxt   = timed_out;
    i2c_data_nxt    = i2c_data;
    reg_index_nxt   = reg_index;
    config_done_nxt = config_done;
    config_err_nxt  = config_err;

    case (state)
      ST_PWRUP: begin
        if (pwr_cnt == PWR_LAST) state_nxt = ST_LOAD;
        else                     pwr_cnt_nxt = pwr_cnt + PWR_W'(1);
      end
      ST_LOAD: begin
        i2c_data_nxt  = {DEV_ADDR, entry.addr, entry.val};
        retry_cnt_nxt = '0;
        gap_cnt_nxt   = '0;
        dly_cnt_nxt   = '0;
        state_nxt     = (entry.addr == DELAY_MARKER) ? ST_DELAY : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          tmo_cnt_nxt   = '0;
          timed_out_nxt = 1'b0;
          state_nxt     = ST_XFER;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      ST_XFER: begin
        // tr_end is ignored on the first XFER cycle so a stale flag cannot complete a transfer.
        if (tr_end && (tmo_cnt != '0)) begin
          state_nxt = ST_CHECK;
        end else if (tmo_cnt == TMO_LAST) begin
          timed_out_nxt = 1'b1;
          state_nxt     = ST_CHECK;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        if (!ack && !timed_out) begin
          state_nxt = ST_NEXT;
        end else if (retry_cnt != RTY_MAX) begin
          retry_cnt_nxt = retry_cnt + RTY_W'(1);
          gap_cnt_nxt   = '0;
          state_nxt     = ST_GAP;
        end else begin
          config_err_nxt = 1'b1;
          state_nxt      = ST_NEXT;
        end
      end
      ST_DELAY: begin
        if (dly_cnt == dly_last) state_nxt = ST_NEXT;
        else                     dly_cnt_nxt = dly_cnt + DLY_W'(1);
      end
      ST_NEXT: begin
        if (reg_index == IDX_LAST) begin
          config_done_nxt = 1'b1;
          state_nxt       = ST_FINISH;
        end else begin
          reg_index_nxt = reg_index + IDX_W'(1);
          state_nxt     = ST_LOAD;
        end
      end
      ST_FINISH: begin
        config_done_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_PWRUP;
      end
    endcase

    start_nxt = (state_nxt == ST_XFER) || (state_nxt == ST_CHECK);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clock_i2c) begin
    if (camera_rst) begin
      state       <= ST_PWRUP;
      pwr_cnt     <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      dly_cnt     <= '0;
      retry_cnt   <= '0;
      timed_out   <= 1'b0;
      i2c_data    <= '0;
      start       <= 1'b0;
      reg_index   <= '0;
      config_done <= 1'b0;
      config_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pwr_cnt     <= pwr_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      dly_cnt     <= dly_cnt_nxt;
      retry_cnt   <= retry_cnt_nxt;
      timed_out   <= timed_out_nxt;
      i2c_data    <= i2c_data_nxt;
      start       <= start_nxt;
      reg_index   <= reg_index_nxt;
      config_done <= config_done_nxt;
      config_err  <= config_err_nxt;
    end
  end

endmodule

// File: doc/camera_reg_config.md
CAMERA_REG_CONFIG -- requirements
Module: camera_reg_config

Interface
REQ-001 Parameter DEV_ADDR, default 8'h78; camera I2C write address, sent as i2c_data[31:24].
REQ-002 Parameter NUM_REGS, default 252; number of table entries, index range 0..NUM_REGS-1.
REQ-003 Parameter PWR_DELAY, default 20000; clock_i2c cycles to wait after reset before the first transfer.
REQ-004 Parameter MAX_RETRY, default 3; retries per entry after a NACK or timeout.
REQ-005 Parameter TIMEOUT, default 63; clock_i2c cycles allowed from start rise to tr_end.
REQ-006 Port clock_i2c, input, 1; the single clock, the same 20 kHz clock that drives the I2C bit engine.
REQ-007 Port camera_rst, input, 1; synchronous, active-high reset.
REQ-008 Port tr_end, input, 1; transfer-complete flag from the bit engine.
REQ-009 Port ack, input, 1; bit-engine response, 0 = all bytes ACKed, valid while tr_end=1.
REQ-010 Port i2c_data, output, 32; {DEV_ADDR, reg_addr[15:0], reg_val[7:0]} for the current entry.
REQ-011 Port start, output, 1; the bit engine runs while start is high and re-arms while it is low.
REQ-012 Port reg_index, output, 9; index of the current entry.
REQ-013 Port config_done, output, 1; sticky, set when all entries have been written.
REQ-014 Port config_err, output, 1; sticky, set when any entry exhausts its retries.

Function
REQ-015 The FSM SHALL have the states PWRUP, LOAD, GAP, XFER, CHECK, DELAY, NEXT, FINISH.
REQ-016 PWRUP SHALL count PWR_DELAY cycles with start=0, then go to LOAD.
REQ-017 LOAD SHALL register the table entry at reg_index into i2c_data, clear the retry count, and go to GAP in the next cycle.
REQ-018 LOAD SHALL go to DELAY instead of GAP when reg_addr==16'hFFFF, using reg_val as a delay count in units of 1024 cycles.
REQ-019 GAP SHALL hold start=0 for exactly 3 cycles so the bit engine resets its counter and clears tr_end, then go to XFER.
REQ-020 XFER SHALL drive start=1 and SHALL go to CHECK on the first cycle in which tr_end=1.
REQ-021 XFER SHALL also go to CHECK if TIMEOUT cycles elapse without tr_end, and this case SHALL count as a NACK.
REQ-022 CHECK SHALL sample ack in the same cycle it is entered, with start still 1.
REQ-023 CHECK SHALL go to NEXT on ack=0.
REQ-024 CHECK SHALL go to GAP on a NACK with retries remaining, incrementing the retry count.
REQ-025 CHECK SHALL set config_err and go to NEXT on a NACK with retries exhausted (MAX_RETRY+1 attempts in total).
REQ-026 DELAY SHALL hold start=0 for reg_val*1024 cycles, then go to NEXT; reg_val=0 SHALL give a 1-cycle delay.
REQ-027 NEXT SHALL drive start=0 and increment reg_index.
REQ-028 NEXT SHALL go to FINISH when reg_index==NUM_REGS-1 (no wrap-around), and to LOAD otherwise.
REQ-029 FINISH SHALL set config_done, hold start=0, and remain in FINISH until reset.
REQ-030 start SHALL be registered and SHALL be high only in XFER and CHECK.
REQ-031 i2c_data SHALL change only in LOAD, so it is stable for the whole time start=1.
REQ-032 If tr_end is already 1 on XFER entry, which is a protocol fault, the block SHALL still wait one full cycle before accepting it.
REQ-033 Counters SHALL be sized from the parameters: the power-up, timeout and delay counters each SHALL be wide enough for their maximum count without overflow.

Reset
REQ-034 On camera_rst=1 at a clock_i2c edge, the block SHALL enter PWRUP with start=0, reg_index=0, i2c_data=0, config_done=0, config_err=0, and all counters at 0.
REQ-035 Reset asserted mid-transfer SHALL drop start in the next cycle and restart the whole table from index 0 after PWR_DELAY.

Structure
REQ-036 A shared package camera_cfg_pkg SHALL hold the FSM state encoding, the DELAY_MARKER constant 16'hFFFF, and the DELAY_UNIT constant 1024.
REQ-037 Sub-module camera_reg_lut SHALL be a combinational index-to-24-bit {reg_addr, reg_val} table holding the OV5640 init list.
REQ-038 camera_reg_lut SHALL return 24'hFFFF00 for out-of-range indices.

Verification
REQ-039 Bench model ACKs every transfer, PWR_DELAY=10, NUM_REGS=4 -> exactly 4 start pulses, each preceded by 3 low cycles; config_done=1, config_err=0.
REQ-040 Entry 1 = {16'h3008, 8'h82} -> i2c_data=32'h78300882 held constant while start=1.
REQ-041 Model NACKs entry 2 twice, then ACKs -> 3 attempts at index 2, config_err=0.
REQ-042 Model NACKs entry 2 always, MAX_RETRY=3 -> 4 attempts, config_err=1, sequence continues to index 3, then config_done=1.
REQ-043 tr_end never asserted -> start drops after 63 cycles in XFER, retried, config_err=1.
REQ-044 Entry {16'hFFFF, 8'h02} -> no start for 2048 cycles; camera_rst pulsed mid-XFER -> start=0 next cycle, reg_index=0.
